// File: rtl/serial_adder_ctrl_pkg.sv
// Shared encodings for the bit-serial add/subtract sequencer and the ALU decoder.
// Also holds the overflow rule used on the final bit.
package serial_adder_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Signed overflow: the carry into the MSB disagrees with the carry out of it.
    function automatic logic ovf_flag(input logic carry_into_msb, input logic carry_out_msb);
        return carry_into_msb ^ carry_out_msb;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder built from two half adders; the only adder cell in the sequencer.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    logic ha0_sum;
    logic ha0_carry;
    logic ha1_carry;

    half_adder u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (ha0_sum),
        .c_out (ha0_carry)
    );

    half_adder u_ha1 (
        .a     (ha0_sum),
        .b     (c_in),
        .sum   (sum),
        .c_out (ha1_carry)
    );

    assign c_out = ha0_carry | ha1_carry;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder, the leaf cell of the serial full adder.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b;
    assign c_out = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full adder is reused over WIDTH cycles,
// with the result shifted in from the MSB and published when done pulses.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c_in  (carry_q),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                // Subtract is a + ~b + 1: invert b and preset the carry.
                if (start) begin
                    state_d = ST_RUN;
                    a_sh_d  = a;
                    b_sh_d  = (op_sub == OP_SUB) ? ~b : b;
                    carry_d = (op_sub == OP_SUB) ? 1'b1 : c_in;
                    cnt_d   = '0;
                    res_d   = '0;
                end
            end
            ST_RUN: begin
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                carry_d = fa_cout;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                // On the MSB, carry_q is still the carry into that bit.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    sum_d   = {fa_sum, res_q[WIDTH-1:1]};
                    c_out_d = fa_cout;
                    ovf_d   = ovf_flag(carry_q, fa_cout);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=2 against an
// integer-arithmetic reference model.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst_n;

    logic       start8, op8, c_in8;
    logic [7:0] a8, b8;
    logic       busy8, done8, c_out8, ovf8;
    logic [7:0] sum8;

    logic       start2, op2, c_in2;
    logic [1:0] a2, b2;
    logic       busy2, done2, c_out2, ovf2;
    logic [1:0] sum2;

    int checks;
    int errors;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .op_sub (op8),
        .a      (a8),
        .b      (b8),
        .c_in   (c_in8),
        .busy   (busy8),
        .done   (done8),
        .sum    (sum8),
        .c_out  (c_out8),
        .ovf    (ovf8)
    );

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start2),
        .op_sub (op2),
        .a      (a2),
        .b      (b2),
        .c_in   (c_in2),
        .busy   (busy2),
        .done   (done2),
        .sum    (sum2),
        .c_out  (c_out2),
        .ovf    (ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain unsigned/signed integer arithmetic on w-bit values.
    function automatic void ref_model(input int w, input longint av, input longint bv,
                                      input bit ci, input bit op,
                                      output longint s, output bit co, output bit ov);
        longint m;
        longint sa;
        longint sb;
        longint u;
        longint r;
        m  = longint'(1) << w;
        sa = (av >= m / 2) ? av - m : av;
        sb = (bv >= m / 2) ? bv - m : bv;
        if (op) begin
            u  = av - bv;
            r  = sa - sb;
            co = (av >= bv);
        end else begin
            u  = av + bv + longint'(ci);
            r  = sa + sb + longint'(ci);
            co = (u >= m);
        end
        s  = ((u % m) + m) % m;
        ov = (r >= m / 2) || (r < -(m / 2));
    endfunction

    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic ci, input logic op,
                        output int lat, output logic [7:0] s, output logic co, output logic ov);
        @(negedge clk);
        for (int k = 0; k < 50 && busy8; k++) @(negedge clk);
        a8 = av; b8 = bv; c_in8 = ci; op8 = op; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); c_in8 = 1'($urandom);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done8) begin
                lat = i;
                break;
            end
        end
        s = sum8; co = c_out8; ov = ovf8;
    endtask

    task automatic run2(input logic [1:0] av, input logic [1:0] bv, input logic ci, input logic op,
                        output int lat, output logic [1:0] s, output logic co, output logic ov);
        @(negedge clk);
        for (int k = 0; k < 50 && busy2; k++) @(negedge clk);
        a2 = av; b2 = bv; c_in2 = ci; op2 = op; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        a2 = 2'($urandom); b2 = 2'($urandom);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done2) begin
                lat = i;
                break;
            end
        end
        s = sum2; co = c_out2; ov = ovf2;
    endtask

    task automatic test_reset;
        int lat;
        logic [7:0] s;
        logic co, ov;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy8, done8, sum8, c_out8, ovf8} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h c_out=%b ovf=%b, required all 0",
                     busy8, done8, sum8, c_out8, ovf8);
        end
        @(negedge clk); rst_n = 1'b1;

        run8(8'hFF, 8'h01, 1'b1, 1'b0, lat, s, co, ov);
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h33; c_in8 = 1'b0; op8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, sum8, c_out8, ovf8} !== 12'h000) begin
            errors++;
            $display("FAIL reset_midrun: busy=%b done=%b sum=%h c_out=%b ovf=%b, required all 0",
                     busy8, done8, sum8, c_out8, ovf8);
        end
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;

        run8(8'h01, 8'h01, 1'b0, 1'b0, lat, s, co, ov);
        checks++;
        if (lat !== 8 || s !== 8'h02) begin
            errors++;
            $display("FAIL reset_recover: lat=%0d sum=%h, required lat=8 sum=02", lat, s);
        end
    endtask

    task automatic test_directed;
        logic [7:0] va [8] = '{8'hFF, 8'hFF, 8'h7F, 8'h80, 8'h03, 8'h05, 8'h00, 8'h80};
        logic [7:0] vb [8] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h05, 8'h03, 8'h00, 8'h80};
        logic       vc [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       vo [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] es [8] = '{8'h00, 8'h01, 8'h80, 8'h7F, 8'hFE, 8'h02, 8'h00, 8'h00};
        logic       ec [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       eo [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int lat;
        logic [7:0] s;
        logic co, ov;
        for (int i = 0; i < 8; i++) begin
            run8(va[i], vb[i], vc[i], vo[i], lat, s, co, ov);
            checks++;
            if (lat !== 8 || s !== es[i] || co !== ec[i] || ov !== eo[i]) begin
                errors++;
                $display("FAIL directed[%0d]: lat=%0d sum=%h c_out=%b ovf=%b, required lat=8 sum=%h c_out=%b ovf=%b",
                         i, lat, s, co, ov, es[i], ec[i], eo[i]);
            end
        end
    endtask

    task automatic test_busy_and_back_to_back;
        int ndone;
        int done_at;
        int lat;
        logic [7:0] s;
        @(negedge clk);
        for (int k = 0; k < 50 && busy8; k++) @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; c_in8 = 1'b0; op8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise: busy=%b, required 1", busy8);
        end
        ndone = 0; done_at = -1; s = 8'hxx;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 3 || i == 9) begin
                start8 = 1'b1; a8 = 8'hAA; b8 = 8'hAA;
            end else begin
                start8 = 1'b0;
            end
            @(posedge clk); #1;
            if (done8) begin
                ndone++; done_at = i; s = sum8;
            end
        end
        start8 = 1'b0;
        checks++;
        if (ndone !== 1 || done_at !== 8 || s !== 8'h30) begin
            errors++;
            $display("FAIL busy_ignore: done_pulses=%0d at=%0d sum=%h, required 1 at 8 sum=30",
                     ndone, done_at, s);
        end
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL busy_fall: busy=%b done=%b, required 0 0", busy8, done8);
        end

        @(negedge clk);
        a8 = 8'h21; b8 = 8'h34; c_in8 = 1'b1; op8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done8) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 8 || sum8 !== 8'h56) begin
            errors++;
            $display("FAIL back_to_back: lat=%0d sum=%h, required lat=8 sum=56", lat, sum8);
        end
    endtask

    task automatic test_random_w8;
        int lat;
        logic [7:0] s, av, bv;
        logic co, ov, ci, op;
        longint es;
        bit ec, eo;
        for (int n = 0; n < 1000; n++) begin
            av = 8'($urandom); bv = 8'($urandom); ci = 1'($urandom); op = 1'($urandom);
            if (n < 8) begin
                av = (n[0]) ? 8'h80 : 8'h7F;
                bv = (n[1]) ? 8'hFF : 8'h80;
            end
            ref_model(8, longint'(av), longint'(bv), ci, op, es, ec, eo);
            run8(av, bv, ci, op, lat, s, co, ov);
            checks++;
            if (lat !== 8 || s !== 8'(es) || co !== ec || ov !== eo) begin
                errors++;
                $display("FAIL random_w8: a=%h b=%h c_in=%b sub=%b got lat=%0d sum=%h c_out=%b ovf=%b, required lat=8 sum=%h c_out=%b ovf=%b",
                         av, bv, ci, op, lat, s, co, ov, 8'(es), ec, eo);
            end
        end
    endtask

    task automatic test_random_w2;
        int lat;
        logic [1:0] s, av, bv;
        logic co, ov, ci, op;
        longint es;
        bit ec, eo;
        for (int n = 0; n < 1000; n++) begin
            av = 2'($urandom); bv = 2'($urandom); ci = 1'($urandom); op = 1'($urandom);
            ref_model(2, longint'(av), longint'(bv), ci, op, es, ec, eo);
            run2(av, bv, ci, op, lat, s, co, ov);
            checks++;
            if (lat !== 2 || s !== 2'(es) || co !== ec || ov !== eo) begin
                errors++;
                $display("FAIL random_w2: a=%h b=%h c_in=%b sub=%b got lat=%0d sum=%h c_out=%b ovf=%b, required lat=2 sum=%h c_out=%b ovf=%b",
                         av, bv, ci, op, lat, s, co, ov, 2'(es), ec, eo);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start8 = 1'b0; op8 = 1'b0; c_in8 = 1'b0; a8 = '0; b8 = '0;
        start2 = 1'b0; op2 = 1'b0; c_in2 = 1'b0; a2 = '0; b2 = '0;

        test_reset();
        test_directed();
        test_busy_and_back_to_back();
        test_random_w8();
        test_random_w2();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
